// File: rtl/l1_mem_responder.sv
// l1_mem_responder: memory-side responder for the L1D miss path.
// Accepts one word load/store at a time, waits a fixed LATENCY, then returns
// read data (loads) or a zero-data acknowledge (stores) on the response channel.
// Optional feature macro: MEM_BURST_EN -- loads return a full line,
// critical-word-first and wrapping within the line; stores stay single-beat.
//
// state | meaning
// IDLE  | ready for a request; a store is written to the array on accept
// WAIT  | latency countdown after accept
// RESP  | response beat(s) on the output; last beat returns to IDLE
module l1_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 4,
    parameter int LINE_WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              l1_mem_valid,
    input  logic              l1_mem_store,
    input  logic [ADDR_W-1:0] l1_mem_addr,
    input  logic [DATA_W-1:0] l1_mem_wdata,
    output logic              mem_l1_ready,
    output logic              mem_l1_valid,
    output logic [DATA_W-1:0] mem_l1_rdata,
    output logic              mem_l1_last
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  lat_q;
    logic              store_q;
    logic [IDX_W-1:0]  idx_q;
    logic              ready_q;
    logic              valid_q;
    logic              last_q;
    logic [DATA_W-1:0] rdata_q;

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    logic              accept;
    logic [IDX_W-1:0]  req_idx;

    assign accept  = l1_mem_valid && ready_q;
    // Upper address bits above the array are dropped, so addresses alias.
    assign req_idx = l1_mem_addr[2 +: IDX_W];

`ifdef MEM_BURST_EN
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    logic [OFF_W-1:0] beat_q;
    logic [OFF_W-1:0] beat_nxt;
    logic [IDX_W-1:0] beat_idx;

    // Next beat wraps inside the line; the line base bits never change.
    assign beat_nxt = beat_q + 1'b1;
    assign beat_idx = {idx_q[IDX_W-1:OFF_W], idx_q[OFF_W-1:0] + beat_nxt};
`endif

    // Byte-address low bits and high alias bits carry no information here.
    logic unused_ok;
    assign unused_ok = ^{l1_mem_addr[1:0], l1_mem_addr[ADDR_W-1:IDX_W+2]} ^ (LINE_WORDS == 0);

    // Word array: stores land on the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && accept && l1_mem_store) begin
            mem_q[req_idx] <= l1_mem_wdata;
        end
    end

    // Request/response FSM with registered handshake and data outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            store_q <= 1'b0;
            idx_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            rdata_q <= '0;
`ifdef MEM_BURST_EN
            beat_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        store_q <= l1_mem_store;
                        idx_q   <= req_idx;
                        ready_q <= 1'b0;
                        lat_q   <= LAT_LOAD;
                        // Always pass through WAIT: with LATENCY=1 the counter
                        // starts at zero and the beat still lands one cycle later.
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_q == '0) begin
                        state_q <= S_RESP;
                        valid_q <= 1'b1;
                        if (store_q) begin
                            rdata_q <= '0;
                            last_q  <= 1'b1;
                        end else begin
                            rdata_q <= mem_q[idx_q];
`ifdef MEM_BURST_EN
                            last_q  <= 1'b0;
`else
                            last_q  <= 1'b1;
`endif
                        end
`ifdef MEM_BURST_EN
                        beat_q <= '0;
`endif
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                S_RESP: begin
                    if (last_q) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        rdata_q <= '0;
                        ready_q <= 1'b1;
                    end
`ifdef MEM_BURST_EN
                    else begin
                        beat_q  <= beat_nxt;
                        rdata_q <= mem_q[beat_idx];
                        last_q  <= (beat_nxt == LAST_BEAT);
                    end
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    rdata_q <= '0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign mem_l1_ready = ready_q;
    assign mem_l1_valid = valid_q;
    assign mem_l1_rdata = rdata_q;
    assign mem_l1_last  = last_q;

endmodule

// File: tb/tb_l1_mem_responder.sv
// Scoreboard bench for l1_mem_responder: a driver issues requests and pushes
// the expected beats (data, last flag, cycle) from a plain word-array model;
// an independent monitor pops and compares every cycle.
module tb_l1_mem_responder;

    localparam int LAT   = 4;
    localparam int LINE  = 8;
    localparam int DEPTH = 4096;
`ifdef MEM_BURST_EN
    localparam int LOAD_BEATS = LINE;
`else
    localparam int LOAD_BEATS = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_store;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_last;

    l1_mem_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .l1_mem_valid (req_valid),
        .l1_mem_store (req_store),
        .l1_mem_addr  (req_addr),
        .l1_mem_wdata (req_wdata),
        .mem_l1_ready (rsp_ready),
        .mem_l1_valid (rsp_valid),
        .mem_l1_rdata (rsp_rdata),
        .mem_l1_last  (rsp_last)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [DEPTH];
    int          cyc    = 0;
    int          acc_t  = 0;
    int          end_c  = -1;
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          lines[4] = '{'h010, 'h100, 'h020, 'hFF8};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s at cycle %0d: got timeout/stray expected event", name, cyc);
    endtask

    function automatic logic [31:0] mk_addr(input int idx);
        return ($urandom() & 32'hFFFF_C000) | (32'(idx) << 2) | ($urandom() & 32'h3);
    endfunction

    // Present a request and hold it until accepted; record expected beats.
    // Called and returns at posedge+1; leaves valid asserted after accept.
    task automatic drive_req(input logic st, input logic [31:0] addr, input logic [31:0] wd);
        int idx;
        int t;
        bit done;
        done = 0;
        req_valid = 1'b1;
        req_store = st;
        req_addr  = addr;
        req_wdata = wd;
        idx = int'(addr[13:2]);
        for (int k = 0; k < 100 && !done; k++) begin
            if (rst_n && rsp_ready) begin
                t = cyc + 1;
                if (st) begin
                    ref_mem[idx] = wd;
                    q.push_back('{data: 32'h0, last: 1'b1, cyc: t + LAT});
                    end_c = t + LAT;
                end else begin
                    for (int i = 0; i < LOAD_BEATS; i++) begin
                        int w;
                        w = (idx & ~(LINE - 1)) | ((idx + i) % LINE);
                        q.push_back('{data: ref_mem[w], last: (i == LOAD_BEATS - 1), cyc: t + LAT + i});
                    end
                    end_c = t + LAT + LOAD_BEATS - 1;
                end
                acc_t = t;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) fail_now("accept_timeout");
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        req_valid = 1'b0;
        rst_n = 1'b0;
        q.delete();
        acc_t = 0;
        end_c = -1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    // Monitor: compares the handshake every cycle and pops one expectation per beat.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (!rst_n) begin
                check("reset_ready", 32'(rsp_ready), 32'd1);
                check("reset_valid", 32'(rsp_valid), 32'd0);
                check("reset_rdata", rsp_rdata, 32'd0);
                check("reset_last", 32'(rsp_last), 32'd0);
            end else begin
                check("ready", 32'(rsp_ready), 32'((cyc >= acc_t && cyc <= end_c) ? 0 : 1));
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    fail_now("missed_beat");
                    void'(q.pop_front());
                end
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("beat_cycle", 32'(cyc), 32'(e.cyc));
                        check("beat_data", rsp_rdata, e.data);
                        check("beat_last", 32'(rsp_last), 32'(e.last));
                    end
                end
            end
        end
    end

    initial begin
        int li;
        int idx;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill the lines used by every load so no load reads unwritten words.
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < LINE; i++) begin
                drive_req(1'b1, mk_addr(lines[l] + i), (lines[l] == 'h100) ? 32'(i) : $urandom());
            end
        end
        idle(2);

        drive_req(1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        idle(8);
        drive_req(1'b0, 32'h0000_0040, 32'h0);
        idle(15);

        // Back-to-back: second request waits while busy and is taken once.
        drive_req(1'b0, 32'h0000_0414, 32'h0);
        drive_req(1'b0, 32'h0000_0048, 32'h0);
        idle(15);

        // Reset two cycles into a pending load, then the store is still visible.
        drive_req(1'b0, 32'h0000_0040, 32'h0);
        idle(2);
        do_reset(3);
        idle(2);
        drive_req(1'b0, 32'h0000_0040, 32'h0);
        idle(15);

        // Reset right after an accepted store: the write must have landed.
        drive_req(1'b1, 32'h0000_0080, 32'h1234_5678);
        idle(1);
        do_reset(2);
        drive_req(1'b0, 32'h0000_0080, 32'h0);
        idle(15);

        for (int n = 0; n < 200; n++) begin
            li  = int'($urandom_range(0, 3));
            idx = lines[li] + int'($urandom_range(0, LINE - 1));
            if ($urandom_range(0, 2) == 0)
                drive_req(1'b1, mk_addr(idx), $urandom());
            else
                drive_req(1'b0, mk_addr(idx), 32'h0);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 3)));
        end

        req_valid = 1'b0;
        for (int k = 0; k < 100 && q.size() > 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() > 0) fail_now("drain_timeout");
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
